// File: rtl/imem_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
//   req    : request valid, held high until the response returns
//   addr   : word address of the outstanding request, stable while req=1
//   rvalid : response valid for the outstanding request
//   rdata  : instruction word returned with rvalid
// master modport: the fetch unit. slave modport: the memory.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// IF stage. Owns the architectural PC, keeps one instruction-memory request
// outstanding, picks the next PC (JAL / predicted branch / pc+4), loads the
// IF/ID pipeline register, honours stall and mispredict redirect.
//
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   stall           : hold PC and IF/ID (hazard unit)
//   predict_fail    : mispredict flush; redirect_pc carries the correct PC
//   imem            : imem_if.master instruction-memory bus
//   bp_pc, bp_imm   : current PC and B-type immediate of imem.rdata to predictor
//   bp_target_pc,
//   bp_predict      : predictor target and taken result for a branch
//   id_valid, id_pc,
//   id_inst,
//   id_predict      : IF/ID pipeline register
//
// Build option: define FETCH_BUF_EN to add a one-entry buffer that keeps a
// response arriving during a stall instead of refetching it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        predict_fail,
  input  logic [31:0] redirect_pc,
  imem_if.master      imem,
  output logic [31:0] bp_pc,
  output logic [31:0] bp_imm,
  input  logic [31:0] bp_target_pc,
  input  logic        bp_predict,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_predict
);

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] PC_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        id_valid_q, id_valid_d;
  logic        id_predict_q, id_predict_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic [31:0] imm_j;
  logic [31:0] next_pc;
  logic        taken;
  logic        buf_full;

`ifdef FETCH_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic        buf_taken_q, buf_taken_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  // The entry's next PC is not stored: pc_q is advanced to it at capture.
  assign buf_full = buf_valid_q;
`else
  assign buf_full = 1'b0;
`endif

  // Immediate decode of the returning instruction.
  assign bp_imm = {{20{imem.rdata[31]}}, imem.rdata[7], imem.rdata[30:25],
                   imem.rdata[11:8], 1'b0};
  assign imm_j  = {{12{imem.rdata[31]}}, imem.rdata[19:12], imem.rdata[20],
                   imem.rdata[30:21], 1'b0};

  // Next-PC selection; adds wrap modulo 2^32 and the result stays word aligned.
  always_comb begin
    next_pc = (pc_q + 32'd4) & PC_MASK;
    taken   = 1'b0;
    case (imem.rdata[6:0])
      OP_JAL: begin
        next_pc = (pc_q + imm_j) & PC_MASK;
        taken   = 1'b1;
      end
      OP_BRANCH: begin
        next_pc = bp_target_pc & PC_MASK;
        taken   = bp_predict;
      end
      default: ;
    endcase
  end

  // Next-state / datapath. Priority: flush, then accept/stall handling.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;
    id_predict_d = id_predict_q;
`ifdef FETCH_BUF_EN
    buf_valid_d  = buf_valid_q;
    buf_taken_d  = buf_taken_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
`endif

    if (predict_fail) begin
      // Flush beats stall; a request still in flight must be drained in DROP.
      pc_d         = redirect_pc & PC_MASK;
      id_valid_d   = 1'b0;
      id_inst_d    = NOP_INST;
      id_predict_d = 1'b0;
`ifdef FETCH_BUF_EN
      buf_valid_d  = 1'b0;
`endif
      case (state_q)
        REQ:     state_d = imem.rvalid ? IDLE : DROP;
        DROP:    if (imem.rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      // Unstalled IF/ID takes a bubble unless something real is delivered below.
      if (!stall) begin
        id_valid_d   = 1'b0;
        id_inst_d    = NOP_INST;
        id_predict_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!stall && !buf_full) begin
            state_d = REQ;
            addr_d  = pc_q;
          end
        end
        REQ: begin
          if (imem.rvalid) begin
            if (!stall) begin
              // Accept and issue the next request back-to-back.
              id_valid_d   = 1'b1;
              id_pc_d      = pc_q;
              id_inst_d    = imem.rdata;
              id_predict_d = taken;
              pc_d         = next_pc;
              addr_d       = next_pc;
            end else begin
`ifdef FETCH_BUF_EN
              buf_valid_d = 1'b1;
              buf_inst_d  = imem.rdata;
              buf_pc_d    = pc_q;
              buf_taken_d = taken;
              pc_d        = next_pc;
`endif
              // Without the buffer the response is dropped and pc_q refetched.
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (imem.rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

`ifdef FETCH_BUF_EN
      // A full buffer implies IDLE, so this never collides with an accept.
      if (!stall && buf_valid_q) begin
        id_valid_d   = 1'b1;
        id_pc_d      = buf_pc_q;
        id_inst_d    = buf_inst_q;
        id_predict_d = buf_taken_q;
        buf_valid_d  = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'h0;
      id_inst_q    <= NOP_INST;
      id_predict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      id_predict_q <= id_predict_d;
    end
  end

`ifdef FETCH_BUF_EN
  always_ff @(posedge clk) begin
    if (!rst) buf_valid_q <= 1'b0;
    else      buf_valid_q <= buf_valid_d;
  end

  // NOTE: buffer payload has no reset; it is only read while buf_valid_q=1.
  always_ff @(posedge clk) begin
    buf_taken_q <= buf_taken_d;
    buf_inst_q  <= buf_inst_d;
    buf_pc_q    <= buf_pc_d;
  end
`endif

  assign imem.req   = (state_q == REQ) || (state_q == DROP);
  assign imem.addr  = addr_q;
  assign bp_pc      = pc_q;
  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_inst    = id_inst_q;
  assign id_predict = id_predict_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Acts as the instruction memory
// (response one cycle after a request is first seen) and as the predictor.
// Builds with or without FETCH_BUF_EN; the stalled-response case checks the
// matching behaviour.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        predict_fail;
  logic [31:0] redirect_pc;
  logic [31:0] bp_pc;
  logic [31:0] bp_imm;
  logic [31:0] bp_target_pc;
  logic        bp_predict;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_predict;

  int n_checks = 0;
  int n_errors = 0;

  imem_if imem ();

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .predict_fail (predict_fail),
    .redirect_pc  (redirect_pc),
    .imem         (imem),
    .bp_pc        (bp_pc),
    .bp_imm       (bp_imm),
    .bp_target_pc (bp_target_pc),
    .bp_predict   (bp_predict),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_predict   (id_predict)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst, input logic pred);
    check({tag, "_id_valid"},   32'(id_valid),   32'(v));
    check({tag, "_id_pc"},      id_pc,           pc);
    check({tag, "_id_inst"},    id_inst,         inst);
    check({tag, "_id_predict"}, 32'(id_predict), 32'(pred));
  endtask

  // Entered in the first cycle of a request; returns in the first cycle of
  // the next one (or of whatever follows the accept).
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                       input bit chk_imm, input logic [31:0] exp_imm);
    check({tag, "_req"},  32'(imem.req), 32'd1);
    check({tag, "_addr"}, imem.addr,     addr);
    tick();
    imem.rvalid = 1'b1;
    imem.rdata  = inst;
    #1;
    check({tag, "_bp_pc"}, bp_pc, addr);
    if (chk_imm) check({tag, "_bp_imm"}, bp_imm, exp_imm);
    tick();
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
  endtask

  initial begin
    rst          = 1'b0;
    stall        = 1'b0;
    predict_fail = 1'b0;
    redirect_pc  = 32'h0;
    bp_target_pc = 32'h0;
    bp_predict   = 1'b0;
    imem.rvalid  = 1'b0;
    imem.rdata   = 32'h0;

    // Reset state
    repeat (3) tick();
    check("rst_req",   32'(imem.req), 32'd0);
    check("rst_bp_pc", bp_pc,         32'h0);
    check_id("rst", 1'b0, 32'h0, NOP, 1'b0);

    // First request one cycle after reset release, then sequential NOPs
    rst = 1'b1;
    tick();
    fetch("seq0", 32'h0, NOP, 1'b0, 32'h0);
    check_id("seq0", 1'b1, 32'h0, NOP, 1'b0);
    fetch("seq1", 32'h4, NOP, 1'b0, 32'h0);
    check_id("seq1", 1'b1, 32'h4, NOP, 1'b0);
    fetch("seq2", 32'h8, NOP, 1'b0, 32'h0);
    check_id("seq2", 1'b1, 32'h8, NOP, 1'b0);
    fetch("seq3", 32'hC, NOP, 1'b0, 32'h0);

    // JAL +0x20 at 0x10 -> 0x30; JAL +0x10 at 0x30 -> 0x40
    fetch("jal20", 32'h10, 32'h0200_006F, 1'b0, 32'h0);
    check_id("jal20", 1'b1, 32'h10, 32'h0200_006F, 1'b1);
    fetch("jal10", 32'h30, 32'h0100_006F, 1'b0, 32'h0);

    // Branch at 0x40 (imm -28) predicted taken to 0x24
    bp_predict   = 1'b1;
    bp_target_pc = 32'h24;
    fetch("br_t", 32'h40, 32'hFE00_02E3, 1'b1, 32'hFFFF_FFE4);
    check_id("br_t", 1'b1, 32'h40, 32'hFE00_02E3, 1'b1);

    // JAL +0x1C at 0x24 back to 0x40; same branch predicted not taken
    fetch("jal1c", 32'h24, 32'h01C0_006F, 1'b0, 32'h0);
    bp_predict   = 1'b0;
    bp_target_pc = 32'h44;
    fetch("br_nt", 32'h40, 32'hFE00_02E3, 1'b1, 32'hFFFF_FFE4);
    check_id("br_nt", 1'b1, 32'h40, 32'hFE00_02E3, 1'b0);

    // JAL +0x3C at 0x44 -> 0x80
    fetch("jal3c", 32'h44, 32'h03C0_006F, 1'b0, 32'h0);

    // Flush while 0x80 outstanding; low bits of redirect are dropped
    check("fl_req",  32'(imem.req), 32'd1);
    check("fl_addr", imem.addr,     32'h80);
    predict_fail = 1'b1;
    redirect_pc  = 32'h0000_0203;
    tick();
    predict_fail = 1'b0;
    check("fl_id_valid",  32'(id_valid), 32'd0);
    check("fl_id_inst",   id_inst,       NOP);
    check("fl_drop_req",  32'(imem.req), 32'd1);
    check("fl_drop_addr", imem.addr,     32'h80);
    check("fl_bp_pc",     bp_pc,         32'h200);
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h0000_006F;
    tick();
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
    check("fl_late_req",      32'(imem.req), 32'd0);
    check("fl_late_id_valid", 32'(id_valid), 32'd0);
    tick();
    fetch("redir", 32'h200, NOP, 1'b0, 32'h0);
    check_id("redir", 1'b1, 32'h200, NOP, 1'b0);

    // Two-cycle stall with the 0x204 response arriving during it
    check("st_addr", imem.addr, 32'h204);
    stall = 1'b1;
    tick();
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h0010_0093;
    tick();
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
    check("st_req", 32'(imem.req), 32'd0);
    check_id("st_hold", 1'b1, 32'h200, NOP, 1'b0);
`ifdef FETCH_BUF_EN
    check("st_bp_pc", bp_pc, 32'h208);
    stall = 1'b0;
    tick();
    check_id("st_buf", 1'b1, 32'h204, 32'h0010_0093, 1'b0);
    check("st_buf_req", 32'(imem.req), 32'd0);
    tick();
`else
    check("st_bp_pc", bp_pc, 32'h204);
    stall = 1'b0;
    tick();
    check("st_rereq_req",      32'(imem.req), 32'd1);
    check("st_rereq_addr",     imem.addr,     32'h204);
    check("st_rereq_id_valid", 32'(id_valid), 32'd0);
    fetch("st_refetch", 32'h204, 32'h0010_0093, 1'b0, 32'h0);
    check_id("st_refetch", 1'b1, 32'h204, 32'h0010_0093, 1'b0);
`endif
    fetch("post_st", 32'h208, NOP, 1'b0, 32'h0);
    check_id("post_st", 1'b1, 32'h208, NOP, 1'b0);

    // Flush and stall together: flush wins
    stall        = 1'b1;
    predict_fail = 1'b1;
    redirect_pc  = 32'hFFFF_FFFC;
    tick();
    stall        = 1'b0;
    predict_fail = 1'b0;
    check("fs_id_valid", 32'(id_valid), 32'd0);
    check("fs_id_inst",  id_inst,       NOP);
    check("fs_bp_pc",    bp_pc,         32'hFFFF_FFFC);
    check("fs_addr",     imem.addr,     32'h20C);
    imem.rvalid = 1'b1;
    tick();
    imem.rvalid = 1'b0;
    check("fs_idle_req", 32'(imem.req), 32'd0);
    tick();

    // Wrap at the top of the address space
    fetch("wrap", 32'hFFFF_FFFC, NOP, 1'b0, 32'h0);
    check_id("wrap", 1'b1, 32'hFFFF_FFFC, NOP, 1'b0);
    fetch("jal100", 32'h0, 32'h1000_006F, 1'b0, 32'h0);
    check_id("jal100", 1'b1, 32'h0, 32'h1000_006F, 1'b1);

    // Reset in the middle of an outstanding request
    check("mr_addr", imem.addr, 32'h100);
    rst = 1'b0;
    tick();
    check("mr_req",   32'(imem.req), 32'd0);
    check("mr_addr0", imem.addr,     32'h0);
    check("mr_bp_pc", bp_pc,         32'h0);
    check_id("mr", 1'b0, 32'h0, NOP, 1'b0);
    rst = 1'b1;
    tick();
    check("mr_restart_req",  32'(imem.req), 32'd1);
    check("mr_restart_addr", imem.addr,     32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
